// File: rtl/ql_bus_pkg.sv
// Shared types and constants for the QL bus-timing / decode slice.
package ql_bus_pkg;

    localparam int unsigned ADDR_W    = 20;
    localparam int unsigned VRAM_SIZE = 32768;

    typedef enum logic [1:0] {
        SPD_X1 = 2'd0,
        SPD_X2 = 2'd1,
        SPD_X4 = 2'd2,
        SPD_X8 = 2'd3
    } speed_t;

    typedef enum logic [1:0] {
        RAM_128K = 2'd0,
        RAM_384K = 2'd1,
        RAM_640K = 2'd2,
        RAM_896K = 2'd3
    } ramcfg_t;

    // TG68K bus states
    localparam logic [1:0] BS_FETCH = 2'b00;
    localparam logic [1:0] BS_IDLE  = 2'b01;
    localparam logic [1:0] BS_READ  = 2'b10;
    localparam logic [1:0] BS_WRITE = 2'b11;

    // Region bases
    localparam logic [ADDR_W-1:0] ROM_BASE = 20'h00000;
    localparam logic [ADDR_W-1:0] IO_BASE  = 20'h18000;
    localparam logic [ADDR_W-1:0] RAM_BASE = 20'h20000;

endpackage

// File: rtl/ql_bus_ctrl_if.sv
// CPU-side bus bundle between the TG68K wrapper and the bus controller.
interface ql_bus_ctrl_if;
    logic [19:0] cpu_addr;
    logic [1:0]  cpu_busstate;
    logic        cpu_rw;
    logic        ext_wait;
    logic        cpu_rd;
    logic        cpu_wr;
    logic        cpu_cycle;
    logic        cpu_clkena;
    logic        sel_rom;
    logic        sel_io;
    logic        sel_ram;
    logic        sel_vram;

    modport master (
        output cpu_addr, cpu_busstate, cpu_rw, ext_wait,
        input  cpu_rd, cpu_wr, cpu_cycle, cpu_clkena,
        input  sel_rom, sel_io, sel_ram, sel_vram
    );

    modport slave (
        input  cpu_addr, cpu_busstate, cpu_rw, ext_wait,
        output cpu_rd, cpu_wr, cpu_cycle, cpu_clkena,
        output sel_rom, sel_io, sel_ram, sel_vram
    );
endinterface

// File: rtl/ql_addr_decode.sv
// Combinational CPU access qualification and ROM/IO/RAM/VRAM select decode.
module ql_addr_decode
    import ql_bus_pkg::*;
#(
    parameter logic [19:0] VRAM_BASE = 20'h20000
) (
    input  logic [19:0] cpu_addr,
    input  logic [1:0]  cpu_busstate,
    input  logic        cpu_rw,
    input  logic [1:0]  ram_cfg,
    output logic        cpu_rd,
    output logic        cpu_wr,
    output logic        sel_rom,
    output logic        sel_io,
    output logic        sel_ram,
    output logic        sel_vram
);

    // One bit wider so a window near the top of the map cannot wrap
    localparam logic [20:0] VRAM_END = 21'(VRAM_BASE) + 21'(VRAM_SIZE);

    logic act;
    logic xram;
    logic in_vram;

    // Access type, expansion RAM banks and window hits
    always_comb begin
        cpu_rd  = (cpu_busstate == BS_FETCH) || (cpu_busstate == BS_READ);
        cpu_wr  = (cpu_busstate == BS_WRITE) && !cpu_rw;
        act     = cpu_rd || cpu_wr;
        xram    = ((cpu_addr[19:18] == 2'b01) && (ram_cfg >= 2'(RAM_384K))) ||
                  ((cpu_addr[19:18] == 2'b10) && (ram_cfg >= 2'(RAM_640K))) ||
                  ((cpu_addr[19:18] == 2'b11) && (ram_cfg == 2'(RAM_896K)));
        in_vram = (cpu_addr >= VRAM_BASE) && (21'(cpu_addr) < VRAM_END);

        sel_rom  = act && (cpu_addr[19:16] == ROM_BASE[19:16]);
        sel_io   = act && (cpu_addr[19:14] == IO_BASE[19:14]);
        sel_ram  = act && ((cpu_addr[19:17] == RAM_BASE[19:17]) || xram);
        sel_vram = act && in_vram;
    end

endmodule

// File: rtl/ql_bus_ctrl.sv
// QL bus timing: phase enables, speed-graded CPU slots, wait states,
// reset stretcher and RAM-size latch; select decode in ql_addr_decode.
module ql_bus_ctrl
    import ql_bus_pkg::*;
#(
    parameter int unsigned DIV_W      = 5,
    parameter int unsigned RST_CYCLES = 4095,
    parameter logic [19:0] VRAM_BASE  = 20'h20000
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         rst_req,
    input  logic [1:0]   speed,
    input  logic [1:0]   ram_req_cfg,
    ql_bus_ctrl_if.slave bus,
    output logic         ce_p,
    output logic         ce_n,
    output logic         ce_vid,
    output logic         ce_sd,
    output logic         ce_bus_p,
    output logic         ce_bus_n,
    output logic         sys_reset,
    output logic [1:0]   ram_cfg
);

    localparam int unsigned RST_W = (RST_CYCLES < 1) ? 1 : $clog2(RST_CYCLES + 1);

    logic [DIV_W-1:0] div;
    logic             duty;
    logic             sub;
    speed_t           speed_q;
    logic             cpu_enable;
    logic [RST_W-1:0] rst_cnt;
    logic             frame_start;
    logic             idle;

    assign frame_start = (div == '0);
    assign idle        = (bus.cpu_busstate == BS_IDLE);

    assign bus.cpu_cycle  = duty & sub;
    assign ce_bus_p       = duty & ce_p;
    assign ce_bus_n       = duty & ce_n;
    assign bus.cpu_clkena = cpu_enable & ce_bus_p;
    assign sys_reset      = (rst_cnt != '0);

    // Free-running phase counter; enables decoded from the pre-increment value
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div    <= '0;
            ce_p   <= 1'b0;
            ce_n   <= 1'b0;
            ce_vid <= 1'b0;
            ce_sd  <= 1'b0;
        end else begin
            div    <= div + DIV_W'(1);
            ce_p   <= (div[2:0] == 3'd0);
            ce_n   <= (div[2:0] == 3'd4);
            ce_vid <= (div[2:0] == 3'd0);
            ce_sd  <= (div[1:0] == 2'd0);
        end
    end

    // Speed grade only changes at a frame boundary; duty picks the CPU phases
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            duty    <= 1'b0;
            sub     <= 1'b0;
            speed_q <= SPD_X1;
        end else begin
            if (div[2:0] == 3'd0) begin
                case (speed_q)
                    SPD_X1, SPD_X2: duty <= (div[4:3] == 2'b00);
                    SPD_X4:         duty <= !div[3];
                    default:        duty <= 1'b1;
                endcase
            end
            if (frame_start) begin
                speed_q <= speed_t'(speed);
                sub     <= (speed_q == SPD_X1) ? !sub : 1'b1;
            end
        end
    end

    // CPU clock enable armed on ce_bus_n; a wait from a slave holds off the next slot
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_enable <= 1'b0;
        end else if (ce_bus_n) begin
            cpu_enable <= (bus.cpu_cycle | idle) & !(bus.ext_wait & !idle);
        end
    end

    // Reset stretcher; a request reloads even on the final decrement
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt <= RST_W'(RST_CYCLES);
        end else if (rst_req) begin
            rst_cnt <= RST_W'(RST_CYCLES);
        end else if (ce_bus_p && (rst_cnt != '0)) begin
            rst_cnt <= rst_cnt - RST_W'(1);
        end
    end

    // RAM size follows the request only while the system is held in reset
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ram_cfg <= 2'(RAM_128K);
        end else if (sys_reset) begin
            ram_cfg <= ram_req_cfg;
        end
    end

    ql_addr_decode #(
        .VRAM_BASE (VRAM_BASE)
    ) u_decode (
        .cpu_addr     (bus.cpu_addr),
        .cpu_busstate (bus.cpu_busstate),
        .cpu_rw       (bus.cpu_rw),
        .ram_cfg      (ram_cfg),
        .cpu_rd       (bus.cpu_rd),
        .cpu_wr       (bus.cpu_wr),
        .sel_rom      (bus.sel_rom),
        .sel_io       (bus.sel_io),
        .sel_ram      (bus.sel_ram),
        .sel_vram     (bus.sel_vram)
    );

endmodule

// File: tb/tb_ql_bus_ctrl.sv
// Directed bench for ql_bus_ctrl: enables, speed grades, waits, reset stretch, decode.
module tb_ql_bus_ctrl;
    import ql_bus_pkg::*;

    localparam int unsigned RST = 20;
    localparam int          LIM = 2000;

    logic       clk_sys;
    logic       reset_n;
    logic       rst_req;
    logic [1:0] speed;
    logic [1:0] ram_req_cfg;
    logic       ce_p, ce_n, ce_vid, ce_sd, ce_bus_p, ce_bus_n, sys_reset;
    logic [1:0] ram_cfg;

    int checks = 0;
    int passes = 0;
    int np, nck;

    ql_bus_ctrl_if bus ();

    ql_bus_ctrl #(
        .DIV_W      (5),
        .RST_CYCLES (RST),
        .VRAM_BASE  (20'h20000)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .rst_req     (rst_req),
        .speed       (speed),
        .ram_req_cfg (ram_req_cfg),
        .bus         (bus),
        .ce_p        (ce_p),
        .ce_n        (ce_n),
        .ce_vid      (ce_vid),
        .ce_sd       (ce_sd),
        .ce_bus_p    (ce_bus_p),
        .ce_bus_n    (ce_bus_n),
        .sys_reset   (sys_reset),
        .ram_cfg     (ram_cfg)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit hit(input int which, input int val);
        case (which)
            0:       hit = ce_bus_p;
            1:       hit = ce_bus_n;
            2:       hit = (int'(dut.div) == val);
            3:       hit = (int'(dut.rst_cnt) == val);
            default: hit = (int'(dut.rst_cnt) == val) && ce_bus_p;
        endcase
    endfunction

    // Bounded wait at negedges; adv forces at least one clock first
    task automatic wait_until(input string tag, input int which, input int val, input bit adv);
        int g = 0;
        if (adv) @(negedge clk_sys);
        while (!hit(which, val) && g < LIM) begin
            @(negedge clk_sys);
            g++;
        end
        chk(tag, 32'(g < LIM), 32'd1);
    endtask

    // Count ce_bus_p and cpu_clkena over whole frames starting at the next frame start
    task automatic measure(input int frames, output int p, output int k);
        p = 0;
        k = 0;
        wait_until("to_frame", 2, 0, 1'b0);
        repeat (32 * frames) begin
            @(negedge clk_sys);
            p += int'(ce_bus_p);
            k += int'(bus.cpu_clkena);
        end
    endtask

    task automatic dec(input string tag, input logic [19:0] a, input logic [1:0] bs, input logic [3:0] exp);
        bus.cpu_addr     = a;
        bus.cpu_busstate = bs;
        #1;
        chk(tag, 32'({bus.sel_rom, bus.sel_io, bus.sel_ram, bus.sel_vram}), 32'(exp));
    endtask

    initial begin
        reset_n          = 1'b0;
        rst_req          = 1'b0;
        speed            = 2'd0;
        ram_req_cfg      = 2'd1;
        bus.cpu_addr     = 20'h0;
        bus.cpu_busstate = BS_READ;
        bus.cpu_rw       = 1'b1;
        bus.ext_wait     = 1'b0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("rst_ce_p", 32'(ce_p), 32'd0);
        chk("rst_ce_n", 32'(ce_n), 32'd0);
        chk("rst_sys_reset", 32'(sys_reset), 32'd1);
        chk("rst_ram_cfg", 32'(ram_cfg), 32'd0);
        chk("rst_clkena", 32'(bus.cpu_clkena), 32'd0);

        // Release: ce_p in cycle 1, ce_n in cycle 5, stretch of RST ce_bus_p pulses
        reset_n = 1'b1;
        np = 0;
        @(negedge clk_sys);
        chk("cyc1_ce_p", 32'(ce_p), 32'd1);
        chk("cyc1_ce_n", 32'(ce_n), 32'd0);
        np += int'(ce_bus_p);
        repeat (3) begin
            @(negedge clk_sys);
            np += int'(ce_bus_p);
        end
        @(negedge clk_sys);
        chk("cyc5_ce_n", 32'(ce_n), 32'd1);
        chk("cyc5_ce_p", 32'(ce_p), 32'd0);
        for (int i = 0; i < 3000 && sys_reset; i++) begin
            @(negedge clk_sys);
            if (sys_reset) np += int'(ce_bus_p);
        end
        chk("stretch_done", 32'(sys_reset), 32'd0);
        chk("stretch_pulses", 32'(np), 32'(RST));
        chk("ram_cfg_latched", 32'(ram_cfg), 32'd1);

        // RAM size request outside reset is ignored
        ram_req_cfg = 2'd3;
        repeat (2) @(negedge clk_sys);
        chk("ram_cfg_hold", 32'(ram_cfg), 32'd1);

        // Decode sweep (ram_cfg = 1)
        dec("dec_40000", 20'h40000, BS_READ, 4'b0010);
        dec("dec_80000", 20'h80000, BS_READ, 4'b0000);
        dec("dec_rom", 20'h0FEE4, BS_READ, 4'b1000);
        dec("dec_io", 20'h18063, BS_READ, 4'b0100);
        dec("dec_vram", 20'h20000, BS_READ, 4'b0011);
        dec("dec_vram_end", 20'h28000, BS_READ, 4'b0010);
        dec("dec_idle", 20'h20000, BS_IDLE, 4'b0000);
        dec("dec_fetch", 20'h0FEE4, BS_FETCH, 4'b1000);
        dec("dec_wr_nwr1", 20'h20000, BS_WRITE, 4'b0000);
        chk("rdwr_nwr1", 32'({bus.cpu_rd, bus.cpu_wr}), 32'b00);
        bus.cpu_rw = 1'b0;
        dec("dec_wr", 20'h20000, BS_WRITE, 4'b0011);
        chk("rdwr_wr", 32'({bus.cpu_rd, bus.cpu_wr}), 32'b01);
        bus.cpu_rw = 1'b1;
        dec("dec_rd", 20'h00100, BS_READ, 4'b1000);
        chk("rdwr_rd", 32'({bus.cpu_rd, bus.cpu_wr}), 32'b10);

        // Normal speed: one CPU slot every other frame
        measure(2, np, nck);
        chk("x1_bus_p_2frames", 32'(np), 32'd2);
        chk("x1_clkena_2frames", 32'(nck), 32'd1);

        // x8: four slots per frame once settled
        speed = 2'd3;
        measure(2, np, nck);
        measure(1, np, nck);
        chk("x8_bus_p", 32'(np), 32'd4);
        chk("x8_clkena", 32'(nck), 32'd4);

        // Back to normal, then 0 -> 2 mid-frame: deferred to next frame
        speed = 2'd0;
        measure(2, np, nck);
        wait_until("to_div17", 2, 17, 1'b0);
        speed = 2'd2;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            np += int'(ce_bus_p);
            if (dut.div == '0) break;
        end
        chk("x1_to_x4_rest", 32'(np), 32'd0);
        measure(1, np, nck);
        chk("x4_bus_p", 32'(np), 32'd2);

        // 2 -> 3 at div 9: remainder of frame keeps the x4 pattern
        wait_until("to_div9", 2, 9, 1'b0);
        speed = 2'd3;
        np = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            np += int'(ce_bus_p);
            if (dut.div == '0) break;
        end
        chk("x4_to_x8_rest", 32'(np), 32'd1);
        measure(1, np, nck);
        chk("x8_bus_p_after", 32'(np), 32'd4);

        // ext_wait across three ce_bus_n with a read: three slots suppressed
        bus.cpu_busstate = BS_READ;
        wait_until("w_n1", 1, 0, 1'b1);
        bus.ext_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_until("w_p", 0, 0, 1'b1);
            chk("wait_suppress", 32'(bus.cpu_clkena), 32'd0);
        end
        wait_until("w_n4", 1, 0, 1'b1);
        bus.ext_wait = 1'b0;
        wait_until("w_p4", 0, 0, 1'b1);
        chk("wait_release", 32'(bus.cpu_clkena), 32'd1);

        // Same wait while idle: no suppression
        bus.cpu_busstate = BS_IDLE;
        wait_until("i_n1", 1, 0, 1'b1);
        bus.ext_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_until("i_p", 0, 0, 1'b1);
            chk("idle_no_suppress", 32'(bus.cpu_clkena), 32'd1);
        end
        bus.ext_wait     = 1'b0;
        bus.cpu_busstate = BS_READ;

        // rst_req pulse re-latches the RAM size
        rst_req = 1'b1;
        @(negedge clk_sys);
        rst_req = 1'b0;
        @(negedge clk_sys);
        chk("rereset_sys_reset", 32'(sys_reset), 32'd1);
        chk("rereset_ram_cfg", 32'(ram_cfg), 32'd3);
        dec("dec_C0000", 20'hC0000, BS_READ, 4'b0010);

        // Reload mid-count
        wait_until("to_cnt5", 3, 5, 1'b0);
        rst_req = 1'b1;
        @(negedge clk_sys);
        rst_req = 1'b0;
        chk("reload_mid", 32'(dut.rst_cnt), 32'(RST));

        // Reload beats the final decrement
        wait_until("to_cnt1", 4, 1, 1'b0);
        rst_req = 1'b1;
        @(negedge clk_sys);
        rst_req = 1'b0;
        chk("reload_final", 32'(dut.rst_cnt), 32'(RST));
        chk("reload_final_sys", 32'(sys_reset), 32'd1);

        np = 0;
        for (int i = 0; i < 3000 && sys_reset; i++) begin
            @(negedge clk_sys);
            if (sys_reset) np += int'(ce_bus_p);
        end
        chk("stretch2_done", 32'(sys_reset), 32'd0);
        chk("stretch2_pulses", 32'(np), 32'(RST));

        // Asynchronous reset mid-frame, between clock edges
        wait_until("to_bus_p", 0, 0, 1'b1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_ce_p", 32'(ce_p), 32'd0);
        chk("async_ce_bus_p", 32'(ce_bus_p), 32'd0);
        chk("async_sys_reset", 32'(sys_reset), 32'd1);
        chk("async_ram_cfg", 32'(ram_cfg), 32'd0);
        chk("async_div", 32'(dut.div), 32'd0);
        chk("async_cycle", 32'(bus.cpu_cycle), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
